// File: rtl/ahb_led_sequencer.sv
// AHB-Lite LED sequencer: register file, step prescaler and 8-bit pattern engine.
// Every output is registered from the next-state values computed in one combinational block.
module ahb_led_sequencer #(
  parameter int PRESCALE_W = 24
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [7:0]  LED,
  output logic        IRQ
);

  localparam logic [1:0] ADDR_PATTERN = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] MODE_STATIC  = 2'b00;
  localparam logic [1:0] MODE_BLINK   = 2'b01;
  localparam logic [1:0] MODE_ROTATE  = 2'b10;
  localparam logic [1:0] MODE_BOUNCE  = 2'b11;

  logic                  dp_act_r, dp_write_r;
  logic [1:0]            dp_addr_r;
  logic [7:0]            pattern_r, pattern_s;
  logic                  en_r, en_s;
  logic [1:0]            mode_r, mode_s;
  logic                  irq_en_r, irq_en_s;
  logic [PRESCALE_W-1:0] period_r, period_s;
  logic [PRESCALE_W-1:0] count_r, count_s;
  logic [7:0]            led_q_r, led_q_s;
  logic                  dir_r, dir_s;
  logic                  pend_r, pend_s;
  logic [7:0]            led_r, led_s;
  logic                  irq_r, irq_s;
  logic [31:0]           hrdata_r, hrdata_s;
  logic                  accept_s, restart_s, clr_s, tick_s;
  logic                  unused_s;

  function automatic logic [7:0] rot_left(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [7:0] rot_right(input logic [7:0] v);
    return {v[0], v[7:1]};
  endfunction

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign HRDATA    = hrdata_r;
  assign LED       = led_r;
  assign IRQ       = irq_r;
  assign unused_s  = ^{HSIZE, HTRANS[0], HADDR[31:4], HADDR[1:0], HWDATA[31:PRESCALE_W]};

  // Next-state for register writes, prescaler, pattern engine, interrupt and read data
  always_comb begin
    accept_s  = HSEL & HREADY & HTRANS[1];
    pattern_s = pattern_r;
    en_s      = en_r;
    mode_s    = mode_r;
    irq_en_s  = irq_en_r;
    period_s  = period_r;
    restart_s = 1'b0;
    clr_s     = 1'b0;
    if (dp_act_r & dp_write_r) begin
      case (dp_addr_r)
        ADDR_PATTERN: begin pattern_s = HWDATA[7:0]; restart_s = 1'b1; end
        ADDR_CTRL: begin
          en_s      = HWDATA[0];
          mode_s    = HWDATA[2:1];
          irq_en_s  = HWDATA[3];
          restart_s = 1'b1;
        end
        ADDR_PERIOD: begin period_s = HWDATA[PRESCALE_W-1:0]; restart_s = 1'b1; end
        default: clr_s = HWDATA[8];
      endcase
    end else begin
      restart_s = 1'b0;
    end

    // a restart in the same cycle swallows the tick entirely
    tick_s = en_r & ~restart_s & (count_r == period_r);
    if (restart_s | ~en_r | tick_s) begin
      count_s = {PRESCALE_W{1'b0}};
    end else begin
      count_s = count_r + PRESCALE_W'(1);
    end

    led_q_s = led_q_r;
    dir_s   = dir_r;
    if (restart_s) begin
      led_q_s = pattern_s;
      dir_s   = 1'b0;
    end else if (!en_r) begin
      led_q_s = pattern_r;
      dir_s   = 1'b0;
    end else if (tick_s || mode_r == MODE_STATIC) begin
      case (mode_r)
        MODE_STATIC: led_q_s = pattern_r;
        MODE_BLINK:  led_q_s = (led_q_r == 8'h00) ? pattern_r : 8'h00;
        MODE_ROTATE: led_q_s = rot_left(led_q_r);
        MODE_BOUNCE: begin
          if (!dir_r && led_q_r[7]) begin
            dir_s   = 1'b1;
            led_q_s = rot_right(led_q_r);
          end else if (dir_r && led_q_r[0]) begin
            dir_s   = 1'b0;
            led_q_s = rot_left(led_q_r);
          end else begin
            led_q_s = dir_r ? rot_right(led_q_r) : rot_left(led_q_r);
          end
        end
        default: led_q_s = led_q_r;
      endcase
    end else begin
      led_q_s = led_q_r;
    end

    if (tick_s & irq_en_r) begin
      pend_s = 1'b1;
    end else if (clr_s) begin
      pend_s = 1'b0;
    end else begin
      pend_s = pend_r;
    end

    led_s = en_s ? led_q_s : 8'h00;
    irq_s = pend_s & irq_en_s;

    // read data reflects register contents during the data phase
    hrdata_s = 32'h0000_0000;
    if (accept_s & ~HWRITE) begin
      case (HADDR[3:2])
        ADDR_PATTERN: hrdata_s = {24'h00_0000, pattern_s};
        ADDR_CTRL:    hrdata_s = {28'h000_0000, irq_en_s, mode_s, en_s};
        ADDR_PERIOD:  hrdata_s = {{(32-PRESCALE_W){1'b0}}, period_s};
        default:      hrdata_s = {22'h00_0000, dir_s, pend_s, led_q_s};
      endcase
    end else begin
      hrdata_s = 32'h0000_0000;
    end
  end

  // State and output registers
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_act_r   <= 1'b0;
      dp_write_r <= 1'b0;
      dp_addr_r  <= 2'd0;
      pattern_r  <= 8'h00;
      en_r       <= 1'b0;
      mode_r     <= 2'b00;
      irq_en_r   <= 1'b0;
      period_r   <= {PRESCALE_W{1'b0}};
      count_r    <= {PRESCALE_W{1'b0}};
      led_q_r    <= 8'h00;
      dir_r      <= 1'b0;
      pend_r     <= 1'b0;
      led_r      <= 8'h00;
      irq_r      <= 1'b0;
      hrdata_r   <= 32'h0000_0000;
    end else begin
      dp_act_r <= accept_s;
      if (accept_s) begin
        dp_write_r <= HWRITE;
        dp_addr_r  <= HADDR[3:2];
      end
      pattern_r <= pattern_s;
      en_r      <= en_s;
      mode_r    <= mode_s;
      irq_en_r  <= irq_en_s;
      period_r  <= period_s;
      count_r   <= count_s;
      led_q_r   <= led_q_s;
      dir_r     <= dir_s;
      pend_r    <= pend_s;
      led_r     <= led_s;
      irq_r     <= irq_s;
      hrdata_r  <= hrdata_s;
    end
  end

endmodule

// File: tb/tb_ahb_led_sequencer.sv
// Scoreboard bench for ahb_led_sequencer: a cycle-level reference model queues the
// expected LED/IRQ/read data per cycle and an independent monitor compares them.
module tb_ahb_led_sequencer;

  logic        HCLK, HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, IRQ;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [7:0]  LED;

  ahb_led_sequencer #(.PRESCALE_W(24)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .LED(LED), .IRQ(IRQ)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [7:0]  led;
    logic        irq;
    bit          rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // reference model state: register contents and cycles elapsed since last restart
  int m_pattern, m_en, m_mode, m_irqen, m_period, m_q, m_dir, m_pend;
  int m_dpv, m_dpw, m_dpa;
  longint m_since;
  logic [31:0] wdata_next;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rotl(input int x);
    return ((x * 2) % 256) + (x / 128);
  endfunction

  function automatic int rotr(input int x);
    return (x / 2) + ((x % 2) * 128);
  endfunction

  task automatic model_reset();
    m_pattern = 0; m_en = 0; m_mode = 0; m_irqen = 0; m_period = 0;
    m_q = 0; m_dir = 0; m_pend = 0; m_dpv = 0; m_dpw = 0; m_dpa = 0; m_since = 0;
  endtask

  // one bus cycle: drive inputs, predict the state after the next edge, advance
  task automatic cycle(input bit act, input bit wr, input int idx, input logic [31:0] d);
    logic [31:0] a;
    int kind;
    int n_pattern, n_en, n_mode, n_irqen, n_period, n_q, n_dir, n_pend;
    bit restart, clr, tick, acc;
    exp_t e;
    a = $urandom;
    a[3:2] = 2'(idx);
    HADDR  = a;
    HSIZE  = 3'($urandom_range(0, 2));
    HWDATA = wdata_next;
    HREADY = 1'b1;
    if (act) begin
      HSEL = 1'b1; HTRANS = 2'($urandom_range(2, 3)); HWRITE = wr;
    end else begin
      kind   = $urandom_range(0, 3);
      HWRITE = 1'($urandom_range(0, 1));
      case (kind)
        0: begin HSEL = 1'b0; HTRANS = 2'b10; end
        1: begin HSEL = 1'b1; HTRANS = 2'b00; end
        2: begin HSEL = 1'b1; HTRANS = 2'b01; end
        default: begin HSEL = (m_dpv == 0); HTRANS = 2'b10; HREADY = 1'b0; end
      endcase
    end
    wdata_next = (act && wr) ? d : 32'($urandom);

    n_pattern = m_pattern; n_en = m_en; n_mode = m_mode; n_irqen = m_irqen;
    n_period = m_period; n_q = m_q; n_dir = m_dir; n_pend = m_pend;
    restart = 1'b0; clr = 1'b0;
    if (m_dpv != 0 && m_dpw != 0) begin
      case (m_dpa)
        0: begin n_pattern = int'(HWDATA[7:0]); restart = 1'b1; end
        1: begin
          n_en = int'(HWDATA[0]); n_mode = int'(HWDATA[2:1]); n_irqen = int'(HWDATA[3]);
          restart = 1'b1;
        end
        2: begin n_period = int'(HWDATA[23:0]); restart = 1'b1; end
        default: clr = HWDATA[8];
      endcase
    end
    tick = (m_en != 0) && !restart &&
           ((m_since % (longint'(m_period) + 1)) == longint'(m_period));

    if (restart) begin
      n_q = n_pattern; n_dir = 0;
    end else if (m_en == 0) begin
      n_q = m_pattern; n_dir = 0;
    end else if (m_mode == 0) begin
      n_q = m_pattern;
    end else if (tick) begin
      if (m_mode == 1) n_q = (m_q == 0) ? m_pattern : 0;
      else if (m_mode == 2) n_q = rotl(m_q);
      else begin
        if (m_dir == 0 && m_q >= 128) n_dir = 1;
        else if (m_dir == 1 && (m_q % 2) == 1) n_dir = 0;
        n_q = (n_dir != 0) ? rotr(m_q) : rotl(m_q);
      end
    end
    if (clr) n_pend = 0;
    if (tick && m_irqen != 0) n_pend = 1;

    acc     = HSEL && HREADY && HTRANS[1];
    e.led   = 8'((n_en != 0) ? n_q : 0);
    e.irq   = (n_pend != 0) && (n_irqen != 0);
    e.rd    = acc && !HWRITE;
    case (HADDR[3:2])
      2'd0:    e.rdata = 32'(n_pattern);
      2'd1:    e.rdata = 32'(n_en + 2 * n_mode + 8 * n_irqen);
      2'd2:    e.rdata = 32'(n_period);
      default: e.rdata = 32'(n_q + 256 * n_pend + 512 * n_dir);
    endcase
    sb.push_back(e);
    kind = int'(HADDR[3:2]);
    wr   = HWRITE;

    @(posedge HCLK);
    if (restart || m_en == 0) m_since = 0;
    else m_since = m_since + 1;
    m_pattern = n_pattern; m_en = n_en; m_mode = n_mode; m_irqen = n_irqen;
    m_period = n_period; m_q = n_q; m_dir = n_dir; m_pend = n_pend;
    m_dpv = int'(acc); m_dpw = int'(wr); m_dpa = kind;
    @(negedge HCLK);
  endtask

  task automatic wr_reg(input int idx, input logic [31:0] d);
    cycle(1'b1, 1'b1, idx, d);
  endtask

  task automatic rd_reg(input int idx);
    cycle(1'b1, 1'b0, idx, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 32'h0);
  endtask

  // asynchronous reset mid-run: LED and IRQ must drop before any clock edge
  task automatic async_reset(input string tag);
    HSEL = 1'b0; HTRANS = 2'b00;
    #2;
    HRESETn = 1'b0;
    #1;
    chk({tag, "_led"}, 32'(LED), 32'h0);
    chk({tag, "_irq"}, 32'(IRQ), 32'h0);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_reset();
  endtask

  // monitor: compares every cycle's registered outputs against the queued prediction
  always @(posedge HCLK) begin
    #1;
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("led", 32'(LED), 32'(e.led));
      chk("irq", 32'(IRQ), 32'(e.irq));
      if (e.rd) chk("hrdata", HRDATA, e.rdata);
    end
  end

  initial begin
    logic [31:0] d;
    int r, idx;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HWDATA = 32'h0; HREADY = 1'b1; wdata_next = 32'h0;
    model_reset();
    repeat (3) @(negedge HCLK);
    chk("reset_led", 32'(LED), 32'h0);
    chk("reset_irq", 32'(IRQ), 32'h0);
    chk("reset_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) rd_reg(i);

    // static
    wr_reg(0, 32'hA5); wr_reg(1, 32'h1); idle(3);
    chk("static_a5", 32'(LED), 32'hA5);
    wr_reg(0, 32'h3C); idle(1);
    chk("static_3c", 32'(LED), 32'h3C);
    rd_reg(0); rd_reg(1);

    // blink, period 3
    wr_reg(0, 32'h0F); wr_reg(2, 32'h3); wr_reg(1, 32'h3); idle(1);
    chk("blink_on0", 32'(LED), 32'h0F);
    idle(3); chk("blink_on3", 32'(LED), 32'h0F);
    idle(1); chk("blink_off", 32'(LED), 32'h00);
    idle(4); chk("blink_on8", 32'(LED), 32'h0F);

    // rotate every cycle
    wr_reg(0, 32'h81); wr_reg(2, 32'h0); wr_reg(1, 32'h5); idle(1);
    chk("rot_0", 32'(LED), 32'h81);
    idle(1); chk("rot_1", 32'(LED), 32'h03);
    idle(1); chk("rot_2", 32'(LED), 32'h06);
    idle(1); chk("rot_3", 32'(LED), 32'h0C);
    idle(5); chk("rot_wrap", 32'(LED), 32'h81);

    // bounce with interrupt, W1C clears on and off a tick
    wr_reg(0, 32'h01); wr_reg(2, 32'h1); wr_reg(1, 32'hF); idle(1);
    chk("bounce_0", 32'(LED), 32'h01);
    chk("bounce_irq0", 32'(IRQ), 32'h0);
    idle(2);
    chk("bounce_1", 32'(LED), 32'h02);
    chk("bounce_irq1", 32'(IRQ), 32'h1);
    for (int i = 0; i < 16; i++) begin idle(1); rd_reg(3); end
    wr_reg(3, 32'h100); wr_reg(3, 32'h100); idle(1); rd_reg(3); idle(1); rd_reg(3);
    wr_reg(3, 32'h100); idle(2); rd_reg(3); idle(6);
    async_reset("arst_bounce");
    for (int i = 0; i < 4; i++) rd_reg(i);

    // restart mid-rotate
    wr_reg(0, 32'h81); wr_reg(2, 32'h0); wr_reg(1, 32'h5); idle(5);
    wr_reg(2, 32'h5); idle(1);
    chk("restart_reload", 32'(LED), 32'h81);
    idle(5); chk("restart_hold", 32'(LED), 32'h81);
    idle(1); chk("restart_step", 32'(LED), 32'h03);
    wr_reg(1, 32'h0); idle(1);
    chk("disable", 32'(LED), 32'h00);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset("arst_rand");
      r   = $urandom_range(0, 99);
      idx = $urandom_range(0, 3);
      if (r < 60) idle(1);
      else if (r < 90) rd_reg(idx);
      else begin
        d = $urandom;
        if (idx == 1) d[0] = ($urandom_range(0, 3) != 0);
        if (idx == 2 && $urandom_range(0, 9) != 0) d = 32'($urandom_range(0, 4));
        if (idx == 3 && $urandom_range(0, 1) != 0) d[8] = 1'b1;
        wr_reg(idx, d);
      end
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_led_sequencer.md
# ahb_led_sequencer

AHB-Lite slave peripheral that owns the board LED bank and sequences patterns onto it autonomously, so firmware on the Cortex-M0 writes a pattern, mode and period once instead of bit-banging the LED port. It sits on the system AHB-Lite bus behind the address decoder (one HSEL) in place of a plain LED register. A programmable prescaler generates step ticks, an 8-bit pattern engine (static / blink / rotate / bounce) drives LED, and an optional interrupt is raised per step.

## Interface
- PRESCALE_W, 24, width of PERIOD register and step counter
- HCLK  in  1  system clock; all logic on rising edge
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select from decoder
- HADDR  in  32  address; only HADDR[3:2] decoded
- HTRANS  in  2  transfer type; HTRANS[1]=1 is valid
- HWRITE  in  1  1=write
- HSIZE  in  3  ignored; all accesses treated as 32-bit
- HWDATA  in  32  write data (data phase)
- HREADY  in  1  bus ready
- HREADYOUT  out  1  constant 1 (zero wait states)
- HRESP  out  1  constant 0 (OKAY)
- HRDATA  out  32  read data
- LED  out  8  LED drive
- IRQ  out  1  step interrupt, level, active high

## Operation
- Registers (offset, reset 0 for all):
  - 0x0 PATTERN[7:0] RW.
  - 0x4 CTRL RW: [0] EN, [2:1] MODE (00 static, 01 blink, 10 rotate-left, 11 bounce), [3] IRQ_EN.
  - 0x8 PERIOD[PRESCALE_W-1:0] RW.
  - 0xC STATUS: read [7:0] current led_q, [8] PEND, [9] DIR (0 left, 1 right); write bit 8 = 1 clears PEND, other bits ignored.
  - Unused read bits return 0.
- Address phase accepted when HSEL & HREADY & HTRANS[1]; HADDR[3:2] and HWRITE registered; write committed at end of the following (data) cycle from HWDATA.
- Step counter: EN=0 holds count=0. EN=1: count increments; when count==PERIOD, tick pulses for one cycle and count returns to 0, giving a tick every PERIOD+1 cycles. PERIOD=0 ticks every cycle.
- Any committed write to PATTERN, CTRL or PERIOD performs a restart: count<=0, led_q<=PATTERN (new value if PATTERN is the register written), DIR<=0.
- EN=0: LED=0x00; led_q<=PATTERN each cycle; DIR<=0.
- EN=1, LED=led_q. Per mode:
  - 00: led_q<=PATTERN every cycle, tick has no effect.
  - 01: on tick, led_q <= (led_q==0) ? PATTERN : 0.
  - 10: on tick, rotate left.
  - 11: on tick, if DIR=0 and led_q[7], set DIR=1 and rotate right; if DIR=1 and led_q[0], set DIR=0 and rotate left; else rotate in DIR.
- Restart overrides a tick in the same cycle.
- IRQ: PEND set on any tick while EN=1 and IRQ_EN=1. Tick set wins over simultaneous W1C. IRQ = PEND & IRQ_EN.

## Timing
- Reset (async assert, sync effect on deassert): LED=0, IRQ=0, HRDATA=0, all registers, count, led_q and DIR = 0.
- Read: HRDATA valid in the data phase, from registers as of that cycle. Back-to-back write-then-read of the same register returns the new value.
- Write to LED effect: led_q updates at the edge ending the write data phase; LED shows the new value the next cycle.
- First tick after restart occurs PERIOD+1 cycles after the restart edge.
- Reset mid-sequence: LED=0 immediately on HRESETn low, without waiting for a clock.

## Test plan
- Reset: HRESETn low → LED=0x00, IRQ=0; all four registers read 0x00000000.
- Static: write PATTERN=0xA5, CTRL=0x1 → LED=0xA5 steady; then PATTERN=0x3C → LED=0x3C two cycles after the write address phase.
- Blink: PATTERN=0x0F, PERIOD=3, CTRL=0x3 → LED alternates 0x0F/0x00 every 4 cycles; first toggle 4 cycles after the CTRL commit.
- Rotate: PATTERN=0x81, PERIOD=0, CTRL=0x5 → LED 0x81,0x03,0x06,0x0C… one per cycle; wraps to 0x81 after 8 steps.
- Bounce with IRQ: PATTERN=0x01, PERIOD=1, CTRL=0xF → LED 0x01,0x02…0x80,0x40…0x01,0x02, stepping every 2 cycles; STATUS.DIR flips at 0x80 and 0x01; IRQ=1 after the first tick; STATUS write 0x100 coinciding with a tick leaves PEND=1; a clear between ticks drops IRQ.
- Restart: mid-rotate, write PERIOD=5 → LED reloads PATTERN, next step exactly 6 cycles later; disable EN → LED=0x00 next cycle.
